// File: rtl/lock_ctrl.sv
// Four-digit passcode lock: synchronized pushbuttons, entry/check FSM with
// auto-relock and a timed, blinking alarm after three failed attempts.
module lock_ctrl #(
    parameter logic [15:0] CODE          = 16'h1234,
    parameter int          RELOCK_CYCLES = 50_000_000,
    parameter int          ALARM_CYCLES  = 250_000_000,
    parameter int          BLINK_CYCLES  = 12_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_enter_n,
    input  logic        key_lock_n,
    input  logic [3:0]  sw_digit,
    output logic [31:0] trigger
);

    localparam int RW = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
    localparam int AW = (ALARM_CYCLES  > 1) ? $clog2(ALARM_CYCLES)  : 1;
    localparam int BW = (BLINK_CYCLES  > 1) ? $clog2(BLINK_CYCLES)  : 1;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        ALARM    = 2'd3
    } state_t;

    state_t          state_r;
    logic [1:0]      enter_sync_r;
    logic [1:0]      lock_sync_r;
    logic            enter_prev_r;
    logic            lock_prev_r;
    logic [1:0]      idx_r;
    logic [1:0]      fail_cnt_r;
    logic [3:0]      digit_r [4];
    logic [RW-1:0]   relock_timer_r;
    logic [AW-1:0]   alarm_timer_r;
    logic [BW-1:0]   blink_timer_r;
    logic            blink_r;
    logic            enter_evt_s;
    logic            lock_evt_s;
    logic            code_ok_s;
    logic [1:0]      fail_next_s;

    assign enter_evt_s = enter_prev_r & ~enter_sync_r[1];
    assign lock_evt_s  = lock_prev_r  & ~lock_sync_r[1];
    assign code_ok_s   = ({digit_r[0], digit_r[1], digit_r[2], digit_r[3]} == CODE);
    assign fail_next_s = fail_cnt_r + 2'd1;

    // Key synchronizers; loading 1 on reset keeps release from looking like a press
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enter_sync_r <= 2'b11;
            lock_sync_r  <= 2'b11;
            enter_prev_r <= 1'b1;
            lock_prev_r  <= 1'b1;
        end else begin
            enter_sync_r <= {enter_sync_r[0], key_enter_n};
            lock_sync_r  <= {lock_sync_r[0], key_lock_n};
            enter_prev_r <= enter_sync_r[1];
            lock_prev_r  <= lock_sync_r[1];
        end
    end

    // Main lock FSM with its entry slots, fail counter and timers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= LOCKED;
            idx_r          <= 2'd0;
            fail_cnt_r     <= 2'd0;
            relock_timer_r <= '0;
            alarm_timer_r  <= '0;
            blink_timer_r  <= '0;
            blink_r        <= 1'b0;
            for (int i = 0; i < 4; i++) digit_r[i] <= 4'd0;
        end else begin
            case (state_r)
                LOCKED: begin
                    if (lock_evt_s) begin
                        idx_r <= 2'd0;
                    end else if (enter_evt_s) begin
                        digit_r[idx_r] <= sw_digit;
                        idx_r          <= idx_r + 2'd1;
                        if (idx_r == 2'd3) state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (code_ok_s) begin
                        state_r        <= UNLOCKED;
                        fail_cnt_r     <= 2'd0;
                        relock_timer_r <= '0;
                    end else begin
                        fail_cnt_r <= fail_next_s;
                        if (fail_next_s == 2'd3) begin
                            state_r       <= ALARM;
                            alarm_timer_r <= '0;
                            blink_timer_r <= '0;
                            blink_r       <= 1'b1;
                        end else begin
                            state_r <= LOCKED;
                        end
                    end
                end
                UNLOCKED: begin
                    if (lock_evt_s || relock_timer_r == RW'(RELOCK_CYCLES - 1)) begin
                        state_r        <= LOCKED;
                        relock_timer_r <= '0;
                    end else begin
                        relock_timer_r <= relock_timer_r + 1'b1;
                    end
                end
                ALARM: begin
                    if (alarm_timer_r == AW'(ALARM_CYCLES - 1)) begin
                        state_r       <= LOCKED;
                        fail_cnt_r    <= 2'd0;
                        idx_r         <= 2'd0;
                        alarm_timer_r <= '0;
                        blink_timer_r <= '0;
                        blink_r       <= 1'b0;
                    end else begin
                        alarm_timer_r <= alarm_timer_r + 1'b1;
                        if (blink_timer_r == BW'(BLINK_CYCLES - 1)) begin
                            blink_timer_r <= '0;
                            blink_r       <= ~blink_r;
                        end else begin
                            blink_timer_r <= blink_timer_r + 1'b1;
                        end
                    end
                end
                default: state_r <= LOCKED;
            endcase
        end
    end

    // Registered status word, one cycle behind the FSM state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trigger <= 32'h0;
        end else begin
            trigger <= {26'd0, fail_cnt_r, idx_r,
                        (state_r == UNLOCKED),
                        (state_r == UNLOCKED) | ((state_r == ALARM) & blink_r)};
        end
    end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with short timer parameters.
module tb_lock_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_enter_n;
    logic        key_lock_n;
    logic [3:0]  sw_digit;
    logic [31:0] trigger;
    int          checks = 0;
    int          errors = 0;

    lock_ctrl #(
        .CODE(16'h1234), .RELOCK_CYCLES(100), .ALARM_CYCLES(200), .BLINK_CYCLES(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_enter_n(key_enter_n), .key_lock_n(key_lock_n),
        .sw_digit(sw_digit), .trigger(trigger)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (trigger === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, trigger, exp);
        end
    endtask

    // press at a negedge, release after 3 edges, settle 3 more; returns at a negedge
    task automatic press(input logic enter, input logic lock, input logic [3:0] d);
        sw_digit    = d;
        key_enter_n = ~enter;
        key_lock_n  = ~lock;
        repeat (3) @(negedge clk);
        key_enter_n = 1'b1;
        key_lock_n  = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic code4(input logic [3:0] a, b, c, d);
        press(1'b1, 1'b0, a);
        press(1'b1, 1'b0, b);
        press(1'b1, 1'b0, c);
        press(1'b1, 1'b0, d);
    endtask

    initial begin
        rst_n = 1'b0; key_enter_n = 1'b1; key_lock_n = 1'b1; sw_digit = 4'd0;
        repeat (3) @(negedge clk);
        check("reset", 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("release_no_event", 32'h0);

        // correct code, then auto relock after 100 cycles
        press(1'b1, 1'b0, 4'd1);
        check("idx1", 32'h4);
        press(1'b1, 1'b0, 4'd2);
        press(1'b1, 1'b0, 4'd3);
        check("idx3", 32'hC);
        press(1'b1, 1'b0, 4'd4);
        check("unlocked", 32'h3);
        press(1'b1, 1'b0, 4'd7);
        check("enter_ignored_unlocked", 32'h3);
        repeat (92) @(negedge clk);
        check("unlocked_last_cycle", 32'h3);
        @(negedge clk);
        check("auto_relock", 32'h0);

        // three failures -> alarm with blinking LED
        code4(4'd1, 4'd2, 4'd3, 4'd5);
        check("fail1", 32'h10);
        code4(4'd1, 4'd2, 4'd3, 4'd5);
        check("fail2", 32'h20);
        code4(4'd1, 4'd2, 4'd3, 4'd5);
        check("alarm_entry", 32'h31);
        repeat (8) @(negedge clk);
        check("blink_on_last", 32'h31);
        @(negedge clk);
        check("blink_off", 32'h30);
        repeat (9) @(negedge clk);
        check("blink_off_last", 32'h30);
        @(negedge clk);
        check("blink_on_again", 32'h31);
        repeat (179) @(negedge clk);
        check("alarm_last", 32'h30);
        @(negedge clk);
        check("alarm_exit", 32'h0);

        // partial entry cleared by lock
        press(1'b1, 1'b0, 4'd1);
        press(1'b1, 1'b0, 4'd2);
        check("partial2", 32'h8);
        press(1'b0, 1'b1, 4'd0);
        check("lock_clears_idx", 32'h0);
        code4(4'd1, 4'd2, 4'd3, 4'd4);
        check("unlock_after_lock", 32'h3);
        press(1'b0, 1'b1, 4'd0);
        check("manual_relock", 32'h0);

        // simultaneous enter+lock, then a held enter key
        press(1'b1, 1'b0, 4'd1);
        press(1'b1, 1'b0, 4'd2);
        press(1'b1, 1'b1, 4'd9);
        check("lock_wins", 32'h0);
        sw_digit = 4'd1;
        key_enter_n = 1'b0;
        repeat (50) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_one_event", 32'h4);
        press(1'b1, 1'b0, 4'd2);
        press(1'b1, 1'b0, 4'd3);
        press(1'b1, 1'b0, 4'd4);
        check("held_then_unlock", 32'h3);
        press(1'b0, 1'b1, 4'd0);

        // wrong code with digit above 9 counts as a failure
        code4(4'd1, 4'd2, 4'd3, 4'hA);
        check("hex_digit_fail", 32'h10);

        // reset after 3 digits
        press(1'b1, 1'b0, 4'd1);
        press(1'b1, 1'b0, 4'd2);
        press(1'b1, 1'b0, 4'd3);
        check("pre_reset_idx3", 32'h1C);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_partial", 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        code4(4'd1, 4'd2, 4'd3, 4'd4);
        check("unlock_after_reset", 32'h3);
        press(1'b0, 1'b1, 4'd0);

        // reset during alarm
        code4(4'd0, 4'd0, 4'd0, 4'd0);
        code4(4'd0, 4'd0, 4'd0, 4'd0);
        code4(4'd0, 4'd0, 4'd0, 4'd0);
        check("alarm2", 32'h31);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_alarm", 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        code4(4'd1, 4'd2, 4'd3, 4'd4);
        check("unlock_after_alarm_reset", 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 SHALL have parameter CODE, 16'h1234: 4-digit passcode, 4 bits per digit, digit 0 in [15:12].
REQ-002 SHALL have parameter RELOCK_CYCLES, 50_000_000: clk cycles spent in UNLOCKED before automatic relock.
REQ-003 SHALL have parameter ALARM_CYCLES, 250_000_000: clk cycles spent in ALARM before returning to LOCKED.
REQ-004 SHALL have parameter BLINK_CYCLES, 12_500_000: LED half-period in ALARM.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port key_enter_n  input  1  raw pushbutton, asynchronous to clk, low = pressed; latches the current digit.
REQ-008 SHALL have port key_lock_n  input  1  raw pushbutton, asynchronous to clk, low = pressed; relocks and clears any entry.
REQ-009 SHALL have port sw_digit  input  4  digit value from switches, sampled on an enter event.
REQ-010 SHALL have port trigger  output  32  status word for the downstream display stage: [0] LED on, [1] unlocked, [3:2] digit index, [5:4] fail count, [31:6] = 0.

Function
REQ-011 SHALL pass each key through a 2-flop synchronizer plus a previous-value register, giving a 1-cycle event pulse on the synced 1->0 transition only; holding a key SHALL produce one event.
REQ-012 SHALL act on a key event at the 3rd rising edge after the key is first sampled low; trigger SHALL reflect the new state 1 cycle later (registered output).
REQ-013 SHALL implement FSM states LOCKED, CHECK, UNLOCKED, ALARM.
REQ-014 In LOCKED, an enter event SHALL store sw_digit into slot idx and increment idx (2 bits); storing the 4th digit (idx=3) SHALL set idx to 0 and move to CHECK.
REQ-015 CHECK SHALL last exactly 1 cycle and compare all 4 stored digits against CODE as raw 4-bit values (values above 9 are allowed and compared as-is).
REQ-016 On match, CHECK SHALL go to UNLOCKED, clear fail_cnt and clear the relock timer.
REQ-017 On mismatch, CHECK SHALL increment fail_cnt; if the new value is 3, it SHALL go to ALARM and clear the alarm and blink timers, otherwise it SHALL go to LOCKED.
REQ-018 In LOCKED, a lock event SHALL clear idx to 0; if enter and lock events occur in the same cycle, lock SHALL win and the digit SHALL be discarded.
REQ-019 UNLOCKED SHALL count clk cycles and return to LOCKED on a lock event or when the timer reaches RELOCK_CYCLES-1; enter events SHALL be ignored there.
REQ-020 ALARM SHALL ignore all key events, toggle the blink bit every BLINK_CYCLES cycles (starting at 1), and after ALARM_CYCLES cycles go to LOCKED with fail_cnt=0 and idx=0.
REQ-021 trigger[0] SHALL be 1 in UNLOCKED, equal to the blink bit in ALARM, and 0 otherwise.
REQ-022 trigger[1] SHALL be 1 only in UNLOCKED.
REQ-023 Timers SHALL be sized by $clog2 of their parameter and SHALL never wrap inside a state.

Reset
REQ-024 While rst_n is low at a clk edge, the block SHALL set: state LOCKED, idx 0, fail_cnt 0, stored digits 0, all timers and blink bit 0, synchronizer flops 1 (released), trigger 32'h0.
REQ-025 Reset SHALL override any state mid-operation, including a partial entry or ALARM; no key event SHALL be generated by the 1 value loaded into the synchronizers on reset release.

Verification (CODE=16'h1234, RELOCK_CYCLES=100, ALARM_CYCLES=200, BLINK_CYCLES=10)
REQ-026 Enter digits 1,2,3,4 -> trigger[1:0]=2'b11 after CHECK; 100 cycles later trigger=32'h0.
REQ-027 Enter 1,2,3,5 three times -> fail count goes 1, 2, then ALARM; trigger[0] toggles every 10 cycles; after 200 cycles trigger=32'h0.
REQ-028 Enter 1,2, then press lock -> trigger[3:2]=0; then enter 1,2,3,4 -> unlocked.
REQ-029 Enter and lock pressed in the same cycle after 2 digits -> idx=0, no digit stored; hold enter for 50 cycles -> exactly one digit stored.
REQ-030 Assert rst_n=0 during ALARM and after 3 digits -> trigger=32'h0 next cycle; 1,2,3,4 then unlocks.
